sentinel_key_prober: RTL and testbench

- Initiator-side companion to the Sentinel core. It drives a candidate key onto the core's dedicated input bus and watches the core's 7-segment output bus for the expected lock/unlock glyph.
- Reports pass, fail or timeout for each probe.
- Used in the FPGA bring-up harness and in self-test wrappers around the Sentinel. It stands in for the stimulus side that the cocotb bench otherwise provides.

---
 rtl/sentinel_key_prober.sv | 189 ++++++++++++++++++
 tb/tb_sentinel_key_prober.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sentinel_key_prober.sv
`default_nettype none
// sentinel_key_prober: presents a candidate key to the Sentinel core and checks
// its 7-segment output for the expected lock/unlock glyph (pass/fail/timeout).
module sentinel_key_prober #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned STABLE_N      = 3,
    parameter int unsigned TIMEOUT       = 16,
    parameter logic [7:0]  GLYPH_UNLOCK  = 8'h3E,
    parameter logic [7:0]  GLYPH_LOCK    = 8'h38,
    parameter logic [7:0]  IDLE_PATTERN  = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [7:0] key_in_i,
    input  logic       expect_unlock_i,
    output logic [7:0] probe_ui_o,
    input  logic [7:0] probe_uo_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic       timeout_o,
    output logic [7:0] last_resp_o
);

    localparam logic [7:0] C_SETTLE  = 8'(SETTLE_CYCLES);
    localparam logic [7:0] C_STABLE  = 8'(STABLE_N);
    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t     state_q,     state_d;
    logic [7:0] key_q,       key_d;
    logic       exp_q,       exp_d;
    logic [7:0] settle_q,    settle_d;
    logic [7:0] match_q,     match_d;
    logic [7:0] sample_q,    sample_d;
    logic [7:0] probe_ui_q,  probe_ui_d;
    logic       busy_q,      busy_d;
    logic       done_q,      done_d;
    logic       pass_q,      pass_d;
    logic       timeout_q,   timeout_d;
    logic [7:0] last_resp_q, last_resp_d;

    logic [7:0] w_glyph;
    logic       w_hit;
    logic [7:0] w_settle_inc;
    logic [7:0] w_match_inc;
    logic [7:0] w_sample_inc;

    assign w_glyph      = exp_q ? GLYPH_UNLOCK : GLYPH_LOCK;
    assign w_hit        = (probe_uo_i == w_glyph);
    assign w_settle_inc = settle_q + 8'd1;
    assign w_match_inc  = match_q + 8'd1;
    assign w_sample_inc = sample_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        exp_d       = exp_q;
        settle_d    = settle_q;
        match_d     = match_q;
        sample_d    = sample_q;
        probe_ui_d  = probe_ui_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        last_resp_d = last_resp_q;

        unique case (state_q)
            ST_IDLE: begin
                probe_ui_d = IDLE_PATTERN;
                busy_d     = 1'b0;
                if (start_i) begin
                    state_d    = ST_DRIVE;
                    key_d      = key_in_i;
                    exp_d      = expect_unlock_i;
                    settle_d   = 8'd0;
                    match_d    = 8'd0;
                    sample_d   = 8'd0;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                    probe_ui_d = key_in_i;
                    busy_d     = 1'b1;
                end
            end

            ST_DRIVE: begin
                if (abort_i) begin
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    probe_ui_d = IDLE_PATTERN;
                end else begin
                    settle_d = w_settle_inc;
                    if (w_settle_inc == C_SETTLE) begin
                        state_d = ST_SAMPLE;
                    end
                end
            end

            ST_SAMPLE: begin
                // Abort wins over a pass or timeout landing on the same edge and
                // leaves last_resp untouched.
                if (abort_i) begin
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    probe_ui_d = IDLE_PATTERN;
                end else begin
                    last_resp_d = probe_uo_i;
                    sample_d    = w_sample_inc;
                    match_d     = w_hit ? w_match_inc : 8'd0;
                    if (w_hit && (w_match_inc == C_STABLE)) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        pass_d     = 1'b1;
                        probe_ui_d = IDLE_PATTERN;
                    end else if (w_sample_inc == C_TIMEOUT) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        timeout_d  = 1'b1;
                        probe_ui_d = IDLE_PATTERN;
                    end
                end
            end

            ST_DONE: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                probe_ui_d = IDLE_PATTERN;
            end

            default: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                probe_ui_d = IDLE_PATTERN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            key_q       <= 8'd0;
            exp_q       <= 1'b0;
            settle_q    <= 8'd0;
            match_q     <= 8'd0;
            sample_q    <= 8'd0;
            probe_ui_q  <= IDLE_PATTERN;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            last_resp_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            exp_q       <= exp_d;
            settle_q    <= settle_d;
            match_q     <= match_d;
            sample_q    <= sample_d;
            probe_ui_q  <= probe_ui_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            last_resp_q <= last_resp_d;
        end
    end

    assign probe_ui_o  = probe_ui_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign timeout_o   = timeout_q;
    assign last_resp_o = last_resp_q;

endmodule
`default_nettype wire

// File: tb/tb_sentinel_key_prober.sv
`default_nettype none
// tb_sentinel_key_prober: randomized probes against a reference model; a monitor
// scores every done pulse against the queued expectation.
module tb_sentinel_key_prober;

    localparam int         SETTLE = 2;
    localparam int         STABLE = 3;
    localparam int         TMO    = 16;
    localparam logic [7:0] G_U    = 8'h3E;
    localparam logic [7:0] G_L    = 8'h38;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_i, abort_i, expect_unlock_i;
    logic [7:0] key_in_i, probe_uo_i;
    logic [7:0] probe_ui_o, last_resp_o;
    logic       busy_o, done_o, pass_o, timeout_o;

    logic       b_start, b_abort, b_exp;
    logic [7:0] b_key, b_uo, b_ui, b_lr;
    logic       b_busy, b_done, b_pass, b_to;

    sentinel_key_prober dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .key_in_i(key_in_i), .expect_unlock_i(expect_unlock_i),
        .probe_ui_o(probe_ui_o), .probe_uo_i(probe_uo_i), .busy_o(busy_o),
        .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
        .last_resp_o(last_resp_o)
    );

    sentinel_key_prober #(.STABLE_N(4), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(b_start), .abort_i(b_abort),
        .key_in_i(b_key), .expect_unlock_i(b_exp),
        .probe_ui_o(b_ui), .probe_uo_i(b_uo), .busy_o(b_busy),
        .done_o(b_done), .pass_o(b_pass), .timeout_o(b_to),
        .last_resp_o(b_lr)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         done_edge;
        bit         pass;
        bit         to;
        logic [7:0] lr;
    } exp_t;

    exp_t       sbq[$];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] lr_model = 8'd0;
    logic [7:0] resp [TMO];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference: walk the sample stream, tracking the run of matching glyphs.
    function automatic exp_t model(input logic [7:0] r [TMO], input logic [7:0] glyph,
                                   input int abort_at, input logic [7:0] prev_lr, input int e0);
        exp_t e;
        int   run;
        int   edge_k;
        e.pass = 1'b0; e.to = 1'b0; e.lr = prev_lr; e.done_edge = 0; run = 0;
        for (int k = 0; k < TMO; k++) begin
            edge_k = SETTLE + 1 + k;
            if (abort_at != 0 && abort_at <= edge_k) begin
                e.done_edge = e0 + abort_at;
                return e;
            end
            e.lr = r[k];
            run  = (r[k] == glyph) ? run + 1 : 0;
            if (run == STABLE) begin
                e.pass = 1'b1;
                e.done_edge = e0 + edge_k;
                return e;
            end
        end
        e.to = 1'b1;
        e.done_edge = e0 + SETTLE + TMO;
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done_o) begin
            if (sbq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done: got done=1, want no pulse (cycle %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                chk("done_edge", 32'(cyc), 32'(e.done_edge));
                chk("pass", 32'(pass_o), 32'(e.pass));
                chk("timeout", 32'(timeout_o), 32'(e.to));
                chk("last_resp", 32'(last_resp_o), 32'(e.lr));
                chk("busy_at_done", 32'(busy_o), 32'd0);
                chk("probe_ui_at_done", 32'(probe_ui_o), 32'd0);
            end
        end
    end

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < TMO; i++) resp[i] = v;
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start_i    = 1'b0;
            abort_i    = 1'($urandom);
            probe_uo_i = 8'($urandom);
        end
    endtask

    task automatic run_probe(input logic [7:0] key, input bit eu, input int abort_at, input bit hold);
        exp_t e;
        int   e0, c, k;
        @(negedge clk);
        chk("idle_probe_ui", 32'(probe_ui_o), 32'd0);
        chk("idle_busy", 32'(busy_o), 32'd0);
        start_i = 1'b1; key_in_i = key; expect_unlock_i = eu; abort_i = 1'b0;
        probe_uo_i = 8'($urandom);
        e0 = cyc + 1;
        e = model(resp, eu ? G_U : G_L, abort_at, lr_model, e0);
        sbq.push_back(e);
        lr_model = e.lr;
        forever begin
            @(negedge clk);
            c = cyc;
            if (c >= e.done_edge) begin
                start_i  = hold;
                key_in_i = 8'($urandom);
                abort_i  = 1'b0;
                break;
            end
            chk("busy_probe_ui", 32'(probe_ui_o), 32'(key));
            chk("busy_flag", 32'(busy_o), 32'd1);
            start_i         = ($urandom % 4 == 0);
            key_in_i        = 8'($urandom);
            expect_unlock_i = 1'($urandom);
            abort_i         = (abort_at != 0) && (c + 1 == e0 + abort_at);
            k = c - e0 - SETTLE;
            probe_uo_i = (k >= 0 && k < TMO) ? resp[k] : 8'($urandom);
        end
    endtask

    initial begin : main
        bit         eu, wrong, hold, seen;
        int         ab, b_e0;
        logic [7:0] glyph, other;

        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; key_in_i = 8'd0;
        expect_unlock_i = 1'b0; probe_uo_i = 8'd0;
        b_start = 1'b0; b_abort = 1'b0; b_exp = 1'b1; b_key = 8'h99; b_uo = G_U;
        repeat (3) @(negedge clk);
        chk("rst_probe_ui", 32'(probe_ui_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_pass", 32'(pass_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_last_resp", 32'(last_resp_o), 32'd0);
        rst_n = 1'b1;

        fill(G_U); run_probe(8'hA5, 1'b1, 0, 1'b0);
        idle_gap(2);
        fill(G_L); run_probe(8'h5A, 1'b0, 0, 1'b0);
        idle_gap(1);
        fill(G_U); run_probe(8'h3C, 1'b0, 0, 1'b0);
        idle_gap(2);
        fill(G_U); resp[1] = 8'h00; run_probe(8'h11, 1'b1, 0, 1'b0);
        idle_gap(1);
        fill(G_U); run_probe(8'h77, 1'b1, 4, 1'b1);
        fill(G_L); run_probe(8'h42, 1'b0, 0, 1'b1);
        fill(G_U); run_probe(8'h24, 1'b1, 0, 1'b0);
        idle_gap(3);

        for (int n = 0; n < 40; n++) begin
            eu    = 1'($urandom);
            glyph = eu ? G_U : G_L;
            other = eu ? G_L : G_U;
            wrong = ($urandom % 5 == 0);
            for (int i = 0; i < TMO; i++)
                resp[i] = wrong ? other : (($urandom % 5 == 0) ? 8'($urandom) : glyph);
            ab   = ($urandom % 5 == 0) ? int'($urandom_range(1, SETTLE + TMO)) : 0;
            hold = ($urandom % 3 == 0);
            run_probe(8'($urandom), eu, ab, hold);
            if (!hold) idle_gap(int'($urandom_range(0, 3)));
        end
        idle_gap(2);

        @(negedge clk);
        start_i = 1'b1; key_in_i = 8'hC3; expect_unlock_i = 1'b1; abort_i = 1'b0; probe_uo_i = G_U;
        @(negedge clk); start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_probe_ui", 32'(probe_ui_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        chk("midrst_last_resp", 32'(last_resp_o), 32'd0);
        chk("midrst_pass", 32'(pass_o), 32'd0);
        @(negedge clk); rst_n = 1'b1; lr_model = 8'd0;
        repeat (25) @(negedge clk);
        chk("post_rst_probe_ui", 32'(probe_ui_o), 32'd0);
        chk("post_rst_busy", 32'(busy_o), 32'd0);

        for (int t = 0; t < 2; t++) begin
            b_uo = (t == 0) ? G_U : 8'h00;
            @(negedge clk); b_start = 1'b1; b_e0 = cyc + 1;
            @(negedge clk); b_start = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (b_done) seen = 1'b1;
            end
            chk("b_done_seen", 32'(seen), 32'd1);
            if (seen) begin
                chk("b_done_edge", 32'(cyc - b_e0), 32'(SETTLE + 4));
                chk("b_pass", 32'(b_pass), (t == 0) ? 32'd1 : 32'd0);
                chk("b_timeout", 32'(b_to), (t == 0) ? 32'd0 : 32'd1);
            end
            repeat (2) @(negedge clk);
        end

        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no completion, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
